// File: rtl/ro_winner_encoder_if.sv
// Result/handshake bundle between the RO counter bank, the winner encoder and the
// PUF response bit generator. The master side arms and consumes; the slave is the encoder.
interface ro_winner_encoder_if #(
    parameter int N_RO  = 16,
    parameter int IDX_W = 4
);
    logic              start;
    logic [0:N_RO-1]   done_vec;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [0:IDX_W-1]  res_idx;
    logic              res_tie;
    logic              res_timeout;
    logic              res_stale;

    modport master (
        output start, done_vec, res_ready,
        input  busy, res_valid, res_idx, res_tie, res_timeout, res_stale
    );

    modport slave (
        input  start, done_vec, res_ready,
        output busy, res_valid, res_idx, res_tie, res_timeout, res_stale
    );
endinterface

// File: rtl/ro_winner_encoder.sv
// Captures the first ring oscillator to finish after arming and holds its encoded index,
// with tie, stale-flag and timeout qualifiers, until the consumer accepts it.
module ro_winner_encoder #(
    parameter int              N_RO    = 16,
    parameter int              IDX_W   = 4,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    ro_winner_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_RESULT
    } state_t;

    // Lowest set index wins, so a one-hot input maps back to its decoder select value.
    function automatic logic [IDX_W-1:0] encode(input logic [0:N_RO-1] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    state_t            r_state;
    logic [TO_W-1:0]   r_cnt;
    logic              r_busy;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tie;
    logic              r_timeout;
    logic              r_stale;

    state_t            w_nextState;
    logic [TO_W-1:0]   w_nextCnt;
    logic [IDX_W-1:0]  w_nextIdx;
    logic              w_nextTie;
    logic              w_nextTimeout;
    logic              w_nextStale;
    logic              w_any;
    logic [IDX_W-1:0]  w_capIdx;
    logic              w_capTie;

    assign w_any    = |bus.done_vec;
    assign w_capIdx = encode(bus.done_vec);
    // Clearing the lowest set bit leaves something only when two or more flags are up.
    assign w_capTie = |(bus.done_vec & (bus.done_vec - N_RO'(1)));

    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextIdx     = r_idx;
        w_nextTie     = r_tie;
        w_nextTimeout = r_timeout;
        w_nextStale   = r_stale;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nextState = S_ARM;
                end
            end
            S_ARM: begin
                if (w_any) begin
                    w_nextState   = S_RESULT;
                    w_nextIdx     = w_capIdx;
                    w_nextTie     = w_capTie;
                    w_nextTimeout = 1'b0;
                    w_nextStale   = 1'b1;
                end else begin
                    w_nextState = S_WAIT;
                    w_nextCnt   = '0;
                end
            end
            S_WAIT: begin
                if (w_any) begin
                    w_nextState   = S_RESULT;
                    w_nextIdx     = w_capIdx;
                    w_nextTie     = w_capTie;
                    w_nextTimeout = 1'b0;
                    w_nextStale   = 1'b0;
                end else if (r_cnt == TIMEOUT - TO_W'(1)) begin
                    w_nextState   = S_RESULT;
                    w_nextIdx     = '0;
                    w_nextTie     = 1'b0;
                    w_nextTimeout = 1'b1;
                    w_nextStale   = 1'b0;
                end else begin
                    w_nextCnt = r_cnt + TO_W'(1);
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // busy and res_valid are registered copies of the next state so no input reaches an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_busy    <= (w_nextState == S_ARM) || (w_nextState == S_WAIT);
            r_valid   <= (w_nextState == S_RESULT);
            r_idx     <= w_nextIdx;
            r_tie     <= w_nextTie;
            r_timeout <= w_nextTimeout;
            r_stale   <= w_nextStale;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.res_valid   = r_valid;
    assign bus.res_idx     = r_idx;
    assign bus.res_tie     = r_tie;
    assign bus.res_timeout = r_timeout;
    assign bus.res_stale   = r_stale;
endmodule
